// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg: FSM encoding, word/pixel derivations and parameter legality check
// shared by the pixel fetch engine.
package pixel_fetch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic int pix_per_word(input int dw, input int pix_w);
      return dw / pix_w;
   endfunction

   function automatic int byte_inc(input int dw);
      return dw / 8;
   endfunction

   function automatic bit params_ok(input int dw, input int pix_w, input int depth, input int burst);
      return (dw == 32) &&
             (pix_w == 8 || pix_w == 16 || pix_w == 32) &&
             (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             (burst >= 1) && (burst <= depth / 2);
   endfunction

endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: synchronous FIFO with registered head-of-queue read data, occupancy/free counts
// and a synchronous flush; rd_dat is valid whenever count is non-zero.
module pf_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           rd_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] free
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign free   = (PW + 1)'(DEPTH) - count;

   always_ff @(posedge i_clk) begin
      if (push && !flush)
         mem[wr_ptr] <= push_dat;
   end

   // rd_dat tracks the head entry; a push into an empty (or draining) queue bypasses memory
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_dat <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, do_pop};
         if (do_pop && count > (PW + 1)'(1))
            rd_dat <= mem[rd_ptr + 1'b1];
         else if (push && (count == '0 || (do_pop && count == (PW + 1)'(1))))
            rd_dat <= push_dat;
      end
   end

   assert property (@(posedge i_clk) disable iff (!i_reset)
                    !(push && !flush && count == (PW + 1)'(DEPTH)));

endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch: Wishbone burst reader filling a FIFO, unpacked into LSB-first pixels on valid/ready.
// Underrun flag/counter are built only when PIXEL_FETCH_UNDERRUN_EN is defined.
module pixel_fetch
   import pixel_fetch_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int PIX_W      = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 8,
   parameter int WCNT_W     = 20
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [AW-1:0]     i_base_addr,
   input  logic [WCNT_W-1:0] i_frame_words,
   input  logic              i_frame_start,
   output logic [PIX_W-1:0]  o_pix_dat,
   output logic              o_pix_valid,
   input  logic              i_pix_ready,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic [AW-1:0]     o_wb_addr,
   output logic [DW/8-1:0]   o_wb_sel,
   input  logic              i_wb_ack,
   input  logic [DW-1:0]     i_wb_dat,
   output logic              o_underrun,
   output logic [15:0]       o_underrun_cnt
);
   localparam int PPW   = pix_per_word(DW, PIX_W);
   localparam int INC   = byte_inc(DW);
   localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int BW    = $clog2(BURST_LEN) + 1;

   if (!params_ok(DW, PIX_W, FIFO_DEPTH, BURST_LEN)) begin : g_bad_params
      $error("pixel_fetch: illegal parameter combination");
   end

   logic [1:0]        st;
   logic [AW-1:0]     addr;
   logic [WCNT_W-1:0] remaining;
   logic [BW-1:0]     beats;
   logic              cyc;
   logic              ack_take;
   logic [DW-1:0]     fifo_dat;
   logic [CW-1:0]     fifo_cnt;
   logic [CW-1:0]     fifo_free;
   logic              fifo_vld;
   logic              fifo_pop;
   logic [DW-1:0]     word;
   logic [IDX_W-1:0]  idx;
   logic              pix_vld;
   logic              consume;
   logic              last;
   logic              need_load;

   // an ack coinciding with a restart belongs to the abandoned frame
   assign ack_take  = cyc && i_wb_ack && !i_frame_start;
   assign o_wb_cyc  = cyc;
   assign o_wb_stb  = cyc;
   assign o_wb_addr = addr;
   assign o_wb_sel  = '1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         st        <= ST_IDLE;
         addr      <= '0;
         remaining <= '0;
         beats     <= '0;
         cyc       <= 1'b0;
      end else if (i_frame_start) begin
         st        <= ST_IDLE;
         addr      <= i_base_addr;
         remaining <= i_frame_words;
         beats     <= '0;
         cyc       <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (remaining == '0) begin
                  st <= ST_DONE;
               end else if (fifo_free >= CW'(BURST_LEN)) begin
                  st    <= ST_BURST;
                  cyc   <= 1'b1;
                  beats <= (remaining < WCNT_W'(BURST_LEN)) ? BW'(remaining) : BW'(BURST_LEN);
               end
            end
            ST_BURST: begin
               if (ack_take) begin
                  addr      <= addr + AW'(INC);
                  remaining <= remaining - 1'b1;
                  beats     <= beats - 1'b1;
                  if (beats == BW'(1)) begin
                     cyc <= 1'b0;
                     st  <= ST_IDLE;
                  end
               end
            end
            ST_DONE: ;
            default: st <= ST_IDLE;
         endcase
      end
   end

   pf_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .flush    (i_frame_start),
      .push     (ack_take),
      .push_dat (i_wb_dat),
      .pop      (fifo_pop),
      .rd_dat   (fifo_dat),
      .count    (fifo_cnt),
      .free     (fifo_free)
   );

   assign fifo_vld  = (fifo_cnt != '0);
   assign consume   = pix_vld && i_pix_ready;
   assign last      = (idx == IDX_W'(PPW - 1));
   assign need_load = !pix_vld || (consume && last);
   assign fifo_pop  = need_load && fifo_vld && !i_frame_start;

   // the word shifts right on each consume so the current pixel is always the low bits
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         word    <= '0;
         idx     <= '0;
         pix_vld <= 1'b0;
      end else if (i_frame_start) begin
         idx     <= '0;
         pix_vld <= 1'b0;
      end else if (need_load) begin
         if (fifo_vld) begin
            word    <= fifo_dat;
            idx     <= '0;
            pix_vld <= 1'b1;
         end else begin
            pix_vld <= 1'b0;
         end
      end else if (consume) begin
         word <= word >> PIX_W;
         idx  <= idx + 1'b1;
      end
   end

   assign o_pix_dat   = word[PIX_W-1:0];
   assign o_pix_valid = pix_vld;

`ifdef PIXEL_FETCH_UNDERRUN_EN
   logic        active;
   logic        frame_end;
   logic        urun_evt;
   logic        urun;
   logic [15:0] urun_cnt;

   // frame ends once every word is fetched and the final pixel leaves the unpacker
   assign frame_end = (remaining == '0) && !cyc && !fifo_vld && (!pix_vld || (consume && last));
   assign urun_evt  = active && !frame_end && i_pix_ready && !pix_vld;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         active   <= 1'b0;
         urun     <= 1'b0;
         urun_cnt <= '0;
      end else if (i_frame_start) begin
         active   <= 1'b1;
         urun     <= 1'b0;
         urun_cnt <= '0;
      end else begin
         if (frame_end)
            active <= 1'b0;
         if (urun_evt) begin
            urun <= 1'b1;
            if (urun_cnt != 16'hFFFF)
               urun_cnt <= urun_cnt + 16'd1;
         end
      end
   end

   assign o_underrun     = urun;
   assign o_underrun_cnt = urun_cnt;
`else
   assign o_underrun     = 1'b0;
   assign o_underrun_cnt = '0;
`endif

endmodule
